// File: rtl/present_core_param.sv
// present_core_param: iterative PRESENT-80/128 core, one round per clock.
// Define PRESENT_DECRYPT_EN to build the KEYPREP state and inverse rounds.
module present_core_param #(
  parameter int KEY_WIDTH  = 80,
  parameter int NUM_ROUNDS = 31
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 decrypt,
  input  logic [KEY_WIDTH-1:0] key,
  input  logic [63:0]          data_in,
  output logic                 ready,
  output logic                 done,
  output logic [63:0]          data_out
);
  localparam logic [4:0] RC_N = 5'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ROUND   = 2'd1,
`ifdef PRESENT_DECRYPT_EN
    S_KEYPREP = 2'd3,
`endif
    S_FINAL   = 2'd2
  } fsm_t;

  if (!(KEY_WIDTH == 80 || KEY_WIDTH == 128)) begin : g_bad_kw
    $error("present_core_param: KEY_WIDTH must be 80 or 128");
  end
  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 31) begin : g_bad_nr
    $error("present_core_param: NUM_ROUNDS must be 1..31");
  end

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC; 4'h1: y = 4'h5; 4'h2: y = 4'h6; 4'h3: y = 4'hB;
      4'h4: y = 4'h9; 4'h5: y = 4'h0; 4'h6: y = 4'hA; 4'h7: y = 4'hD;
      4'h8: y = 4'h3; 4'h9: y = 4'hE; 4'hA: y = 4'hF; 4'hB: y = 4'h8;
      4'hC: y = 4'h4; 4'hD: y = 4'h7; 4'hE: y = 4'h1; default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = sbox(x[4*i +: 4]);
    return y;
  endfunction

  // bit i moves to 16*i mod 63; bit 63 stays put
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) y[(i * 16) % 63] = x[i];
    y[63] = x[63];
    return y;
  endfunction

`ifdef PRESENT_DECRYPT_EN
  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5; 4'h1: y = 4'hE; 4'h2: y = 4'hF; 4'h3: y = 4'h8;
      4'h4: y = 4'hC; 4'h5: y = 4'h1; 4'h6: y = 4'h2; 4'h7: y = 4'hD;
      4'h8: y = 4'hB; 4'h9: y = 4'h4; 4'hA: y = 4'h6; 4'hB: y = 4'h3;
      4'hC: y = 4'h0; 4'hD: y = 4'h7; 4'hE: y = 4'h9; default: y = 4'hA;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] inv_s_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = inv_sbox(x[4*i +: 4]);
    return y;
  endfunction

  function automatic logic [63:0] inv_p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) y[i] = x[(i * 16) % 63];
    y[63] = x[63];
    return y;
  endfunction
`endif

  fsm_t                 fsm_q;
  logic [63:0]          state_q;
  logic [KEY_WIDTH-1:0] key_q;
  logic [4:0]           rc_q;
  logic                 ready_q;
  logic                 done_q;
  logic [63:0]          dout_q;

  logic                 accept;
  logic [63:0]          rk;
  logic [63:0]          enc_st;
  logic [63:0]          enc_out;
  logic [KEY_WIDTH-1:0] key_fwd;

  assign accept  = ready_q & start;
  assign rk      = key_q[KEY_WIDTH-1 -: 64];
  assign enc_st  = p_layer(s_layer(state_q ^ rk));
  assign enc_out = enc_st ^ key_fwd[KEY_WIDTH-1 -: 64];

`ifdef PRESENT_DECRYPT_EN
  logic                 dec_q;
  logic [63:0]          dec_st;
  logic [63:0]          dec_out;
  logic [KEY_WIDTH-1:0] key_inv;

  assign dec_st  = inv_s_layer(inv_p_layer(state_q ^ rk));
  assign dec_out = dec_st ^ key_inv[KEY_WIDTH-1 -: 64];
`else
  logic unused_decrypt;
  assign unused_decrypt = decrypt;
`endif

  if (KEY_WIDTH == 128) begin : g_k128
    logic [127:0] rot;
    // forward schedule: rotl 61, two top nibbles through S, rc into [66:62]
    always_comb begin
      rot = {key_q[66:0], key_q[127:67]};
      key_fwd = rot;
      key_fwd[127:124] = sbox(rot[127:124]);
      key_fwd[123:120] = sbox(rot[123:120]);
      key_fwd[66:62] = rot[66:62] ^ rc_q;
    end
`ifdef PRESENT_DECRYPT_EN
    logic [127:0] un;
    // inverse schedule: undo rc, undo S, rotr 61
    always_comb begin
      un = key_q;
      un[66:62] = key_q[66:62] ^ rc_q;
      un[127:124] = inv_sbox(key_q[127:124]);
      un[123:120] = inv_sbox(key_q[123:120]);
      key_inv = {un[60:0], un[127:61]};
    end
`endif
  end else begin : g_k80
    logic [79:0] rot;
    // forward schedule: rotl 61, top nibble through S, rc into [19:15]
    always_comb begin
      rot = {key_q[18:0], key_q[79:19]};
      key_fwd = rot;
      key_fwd[79:76] = sbox(rot[79:76]);
      key_fwd[19:15] = rot[19:15] ^ rc_q;
    end
`ifdef PRESENT_DECRYPT_EN
    logic [79:0] un;
    // inverse schedule: undo rc, undo S, rotr 61
    always_comb begin
      un = key_q;
      un[19:15] = key_q[19:15] ^ rc_q;
      un[79:76] = inv_sbox(key_q[79:76]);
      key_inv = {un[60:0], un[79:61]};
    end
`endif
  end

  // control FSM and datapath registers; done/ready/data_out are registered
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      key_q   <= '0;
      rc_q    <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      dout_q  <= '0;
`ifdef PRESENT_DECRYPT_EN
      dec_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q <= data_in;
        key_q   <= key;
        rc_q    <= 5'd1;
        ready_q <= 1'b0;
`ifdef PRESENT_DECRYPT_EN
        dec_q   <= decrypt;
        fsm_q   <= decrypt ? S_KEYPREP : S_ROUND;
`else
        fsm_q   <= S_ROUND;
`endif
      end else begin
        unique case (fsm_q)
`ifdef PRESENT_DECRYPT_EN
          S_KEYPREP: begin
            key_q <= key_fwd;
            if (rc_q == RC_N) fsm_q <= S_ROUND;
            else rc_q <= rc_q + 5'd1;
          end
`endif
          S_ROUND: begin
`ifdef PRESENT_DECRYPT_EN
            if (dec_q) begin
              state_q <= dec_st;
              key_q   <= key_inv;
              if (rc_q == 5'd1) begin
                fsm_q   <= S_FINAL;
                dout_q  <= dec_out;
                done_q  <= 1'b1;
                ready_q <= 1'b1;
              end else begin
                rc_q <= rc_q - 5'd1;
              end
            end else
`endif
            begin
              state_q <= enc_st;
              key_q   <= key_fwd;
              if (rc_q == RC_N) begin
                fsm_q   <= S_FINAL;
                dout_q  <= enc_out;
                done_q  <= 1'b1;
                ready_q <= 1'b1;
              end else begin
                rc_q <= rc_q + 5'd1;
              end
            end
          end
          S_FINAL: fsm_q <= S_IDLE;
          default: fsm_q <= S_IDLE;
        endcase
      end
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign data_out = dout_q;

endmodule

// File: tb/tb_present_core_param.sv
// tb_present_core_param: directed checks of the PRESENT core,
// 80-bit and 128-bit key instances side by side.
module tb_present_core_param;
  localparam int N = 31;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start80 = 1'b0;
  logic         start128 = 1'b0;
  logic         decrypt = 1'b0;
  logic [127:0] key_w = '0;
  logic [63:0]  data_in = '0;
  logic         ready80, done80, ready128, done128;
  logic [63:0]  dout80, dout128;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] K80F = {48'h0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF};
  localparam logic [63:0]  ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  present_core_param #(.KEY_WIDTH(80), .NUM_ROUNDS(N)) u80 (
    .clk(clk), .rstn(rstn), .start(start80), .decrypt(decrypt),
    .key(key_w[79:0]), .data_in(data_in),
    .ready(ready80), .done(done80), .data_out(dout80)
  );

  present_core_param #(.KEY_WIDTH(128), .NUM_ROUNDS(N)) u128 (
    .clk(clk), .rstn(rstn), .start(start128), .decrypt(decrypt),
    .key(key_w), .data_in(data_in),
    .ready(ready128), .done(done128), .data_out(dout128)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one block through the selected instance; lat = edges after accept
  task automatic run_block(input bit w128, input logic [127:0] k,
                           input logic [63:0] pt, input bit dec,
                           output logic [63:0] res, output int lat,
                           output bit ok);
    int n;
    ok = 1'b0;
    lat = 0;
    res = '0;
    n = 0;
    while (!(w128 ? ready128 : ready80) && n < 200) begin
      tick();
      n++;
    end
    key_w = k;
    data_in = pt;
    decrypt = dec;
    if (w128) start128 = 1'b1;
    else start80 = 1'b1;
    tick();
    start80 = 1'b0;
    start128 = 1'b0;
    decrypt = 1'b0;
    n = 0;
    while (n < 300) begin
      tick();
      n++;
      if (w128 ? done128 : done80) begin
        ok = 1'b1;
        break;
      end
    end
    lat = n;
    res = w128 ? dout128 : dout80;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    checks += 4;
    if (ready80 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready80 got %b want 1", ready80);
    end
    if (done80 !== 1'b0) begin
      errors++;
      $display("FAIL reset_done80 got %b want 0", done80);
    end
    if (dout80 !== 64'h0) begin
      errors++;
      $display("FAIL reset_dout80 got %h want 0", dout80);
    end
    if (ready128 !== 1'b1 || done128 !== 1'b0 || dout128 !== 64'h0) begin
      errors++;
      $display("FAIL reset_u128 got r%b d%b %h want r1 d0 0",
               ready128, done128, dout128);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_encrypt80();
    logic [127:0] kt [4];
    logic [63:0]  pt [4];
    logic [63:0]  ex [4];
    logic [63:0]  res;
    int lat;
    bit ok;
    kt = '{128'h0, K80F, 128'h0, K80F};
    pt = '{64'h0, 64'h0, ONES, ONES};
    ex = '{64'h5579C1387B228445, 64'hE72C46C0F5945049,
           64'hA112FFC72F68417B, 64'h3333DCD3213210D2};
    for (int i = 0; i < 4; i++) begin
      run_block(1'b0, kt[i], pt[i], 1'b0, res, lat, ok);
      checks += 2;
      if (!ok || res !== ex[i]) begin
        errors++;
        $display("FAIL enc80_data[%0d] got %h want %h", i, res, ex[i]);
      end
      if (lat !== N) begin
        errors++;
        $display("FAIL enc80_latency[%0d] got %0d want %0d", i, lat, N);
      end
    end
  endtask

  task automatic test_encrypt128();
    logic [63:0] res;
    int lat;
    bit ok;
    run_block(1'b1, 128'h0, 64'h0, 1'b0, res, lat, ok);
    checks += 2;
    if (!ok || res !== 64'h96DB702A2E6900AF) begin
      errors++;
      $display("FAIL enc128_data got %h want 96db702a2e6900af", res);
    end
    if (lat !== N) begin
      errors++;
      $display("FAIL enc128_latency got %0d want %0d", lat, N);
    end
  endtask

  task automatic test_ignore_start();
    int n;
    int lat;
    int extra;
    bit seen;
    n = 0;
    while (!ready80 && n < 200) begin
      tick();
      n++;
    end
    key_w = 128'h0;
    data_in = 64'h0;
    start80 = 1'b1;
    tick();
    start80 = 1'b0;
    seen = 1'b0;
    lat = 0;
    for (int c = 1; c <= 200 && !seen; c++) begin
      tick();
      start80 = 1'b0;
      if (done80) begin
        seen = 1'b1;
        lat = c;
      end else if (c == 5 || c == 20) begin
        checks++;
        if (ready80 !== 1'b0) begin
          errors++;
          $display("FAIL busy_ready[%0d] got %b want 0", c, ready80);
        end
        key_w = K80F;
        data_in = ONES;
        start80 = 1'b1;
      end
    end
    checks += 2;
    if (!seen || dout80 !== 64'h5579C1387B228445) begin
      errors++;
      $display("FAIL ignore_data got %h want 5579c1387b228445", dout80);
    end
    if (lat !== N) begin
      errors++;
      $display("FAIL ignore_latency got %0d want %0d", lat, N);
    end
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done80) extra++;
    end
    checks++;
    if (extra !== 0 || ready80 !== 1'b1) begin
      errors++;
      $display("FAIL no_queue got %0d dones ready %b want 0 dones ready 1",
               extra, ready80);
    end
  endtask

  task automatic test_back_to_back();
    int t [3];
    logic [63:0] d [3];
    logic r [3];
    int nd;
    int cyc;
    int et [3];
    logic [63:0] ed [3];
    et = '{N, 2 * N + 1, 3 * N + 2};
    ed = '{64'h5579C1387B228445, 64'hA112FFC72F68417B,
           64'hA112FFC72F68417B};
    t = '{-1, -1, -1};
    d = '{64'h0, 64'h0, 64'h0};
    r = '{1'b0, 1'b0, 1'b0};
    key_w = 128'h0;
    data_in = 64'h0;
    start80 = 1'b1;
    tick();
    data_in = ONES;
    nd = 0;
    cyc = 0;
    while (nd < 3 && cyc < 150) begin
      tick();
      cyc++;
      if (done80) begin
        t[nd] = cyc;
        d[nd] = dout80;
        r[nd] = ready80;
        nd++;
      end
    end
    start80 = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks += 3;
      if (t[i] !== et[i]) begin
        errors++;
        $display("FAIL b2b_time[%0d] got %0d want %0d", i, t[i], et[i]);
      end
      if (d[i] !== ed[i]) begin
        errors++;
        $display("FAIL b2b_data[%0d] got %h want %h", i, d[i], ed[i]);
      end
      if (r[i] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d] got %b want 1", i, r[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] res;
    int lat;
    int n;
    bit ok;
    bit stray;
    n = 0;
    while (!ready80 && n < 200) begin
      tick();
      n++;
    end
    key_w = K80F;
    data_in = 64'h0;
    start80 = 1'b1;
    tick();
    start80 = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    #2;
    rstn = 1'b0;
    #1;
    checks += 3;
    if (ready80 !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready got %b want 1", ready80);
    end
    if (done80 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_done got %b want 0", done80);
    end
    if (dout80 !== 64'h0) begin
      errors++;
      $display("FAIL midrst_dout got %h want 0", dout80);
    end
    stray = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done80) stray = 1'b1;
    end
    rstn = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done80) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0) begin
      errors++;
      $display("FAIL midrst_stray_done got 1 want 0");
    end
    run_block(1'b0, K80F, 64'h0, 1'b0, res, lat, ok);
    checks++;
    if (!ok || res !== 64'hE72C46C0F5945049) begin
      errors++;
      $display("FAIL midrst_rerun got %h want e72c46c0f5945049", res);
    end
  endtask

`ifdef PRESENT_DECRYPT_EN
  task automatic test_decrypt();
    logic [63:0] res;
    logic [63:0] ct;
    logic [63:0] pt;
    logic [127:0] k;
    int lat;
    bit ok;
    bit ok2;
    run_block(1'b0, 128'h0, 64'h5579C1387B228445, 1'b1, res, lat, ok);
    checks += 2;
    if (!ok || res !== 64'h0) begin
      errors++;
      $display("FAIL dec80_data got %h want 0", res);
    end
    if (lat !== 2 * N) begin
      errors++;
      $display("FAIL dec80_latency got %0d want %0d", lat, 2 * N);
    end
    run_block(1'b1, 128'h0, 64'h96DB702A2E6900AF, 1'b1, res, lat, ok);
    checks++;
    if (!ok || res !== 64'h0) begin
      errors++;
      $display("FAIL dec128_data got %h want 0", res);
    end
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 200; i++) begin
        k = {$urandom, $urandom, $urandom, $urandom};
        if (w == 0) k[127:80] = '0;
        pt = {$urandom, $urandom};
        run_block(w[0], k, pt, 1'b0, ct, lat, ok);
        run_block(w[0], k, ct, 1'b1, res, lat, ok2);
        checks++;
        if (!ok || !ok2 || res !== pt) begin
          errors++;
          $display("FAIL roundtrip[w%0d,%0d] got %h want %h", w, i, res, pt);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_encrypt80();
    test_encrypt128();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
`ifdef PRESENT_DECRYPT_EN
    test_decrypt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
